obuf4_pin_arbiter: RTL and testbench

- Shares the board's 4-bit output pin group between NUM_REQ internal requesters (test-pattern, strobe and debug sources on the stand).
- Round-robin arbitration with a bounded hold time per grant.
- Produces a registered 4-bit pin word and a one-hot grant vector. The pin word feeds the existing 4-bit output-buffer wrapper directly.
- Between grants the pins are driven to a fixed idle value.

---
 rtl/obuf4_pin_arbiter_pkg.sv | 26 ++
 rtl/obuf4_pin_arbiter_if.sv | 31 +++
 rtl/obuf4_pin_arbiter_rr_pick.sv | 50 +++++
 rtl/obuf4_pin_arbiter.sv | 166 ++++++++++++++++
 tb/tb_obuf4_pin_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/obuf4_pin_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// obuf4_pin_arbiter_pkg
// Shared definitions for the 4-bit output pin arbiter and related stand
// arbiters: FSM state encoding, default idle pin value, hold counter width and
// a helper that sizes round-robin pointers.
// No ports (package).
// -----------------------------------------------------------------------------
package obuf4_pin_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam logic [3:0] IDLE_VAL_DEFAULT = 4'b0000;

    // Hold counter width; covers MAX_HOLD up to 255.
    localparam int HOLD_W = 8;

    // Pointer width for an n-way round-robin (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obuf4_pin_arbiter_if.sv
// -----------------------------------------------------------------------------
// obuf4_pin_arbiter_if
// Request/data/grant bundle between the pin requesters and the arbiter.
//   req_i     : per-requester request level
//   data_i    : packed pin words, requester k on [4k+3:4k]
//   gnt_o     : one-hot registered grant
//   pins_o    : registered pin word to the output-buffer wrapper
//   busy_o    : arbiter not idle
//   timeout_o : grant ended on the hold limit (one-cycle pulse)
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface obuf4_pin_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_i;
    logic [4*NUM_REQ-1:0] data_i;
    logic [NUM_REQ-1:0]   gnt_o;
    logic [3:0]           pins_o;
    logic                 busy_o;
    logic                 timeout_o;

    modport master (
        output req_i, data_i,
        input  gnt_o, pins_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, data_i,
        output gnt_o, pins_o, busy_o, timeout_o
    );
endinterface

// File: rtl/obuf4_pin_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// obuf4_pin_arbiter_rr_pick
// Combinational round-robin picker: returns the first set request bit found
// scanning upward from i_ptr, wrapping modulo N.
//   i_req    : request vector
//   i_ptr    : scan start index (must be < N)
//   o_winner : one-hot winner (zero when no request)
//   o_valid  : any request present
// -----------------------------------------------------------------------------
module obuf4_pin_arbiter_rr_pick
    import obuf4_pin_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_winner,
    output logic             o_valid
);

    logic [PTR_W:0]   w_sum [N];
    logic [PTR_W-1:0] w_idx [N];
    logic             w_found;

    // w_idx[gi] is the requester examined at scan position gi.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_idx
            assign w_sum[gi] = {1'b0, i_ptr} + (PTR_W+1)'(gi);
            assign w_idx[gi] = (w_sum[gi] >= (PTR_W+1)'(N))
                             ? PTR_W'(w_sum[gi] - (PTR_W+1)'(N))
                             : PTR_W'(w_sum[gi]);
        end
    endgenerate

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[w_idx[i]]) begin
                w_found            = 1'b1;
                o_winner[w_idx[i]] = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/obuf4_pin_arbiter.sv
// -----------------------------------------------------------------------------
// obuf4_pin_arbiter
// Shares the 4-bit output pin group between NUM_REQ requesters with
// round-robin arbitration and a bounded hold time per grant. Pins sit at
// IDLE_VAL whenever no grant is active.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : obuf4_pin_arbiter_if.slave (req_i, data_i, gnt_o, pins_o,
//          busy_o, timeout_o)
// Build option: define OBUF4_PIN_ARBITER_GUARD_EN to add a GUARD state of
// GUARD_CYC cycles at IDLE_VAL after every grant (GUARD_CYC exists only then).
// -----------------------------------------------------------------------------
module obuf4_pin_arbiter
    import obuf4_pin_arbiter_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         MAX_HOLD = 16,
    parameter logic [3:0] IDLE_VAL = IDLE_VAL_DEFAULT
`ifdef OBUF4_PIN_ARBITER_GUARD_EN
    , parameter int       GUARD_CYC = 2
`endif
) (
    input  logic                clk,
    input  logic                rst,
    obuf4_pin_arbiter_if.slave  bus
);

    localparam int              PTR_W     = ptr_width(NUM_REQ);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t               r_state, w_state_next;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_next;
    logic [PTR_W-1:0]     r_idx, w_idx_next;
    logic [PTR_W-1:0]     r_rr_ptr, w_rr_ptr_next;
    logic [3:0]           r_pins, w_pins_next;
    logic                 r_timeout, w_timeout_next;
    logic [HOLD_W-1:0]    r_hold, w_hold_next;
`ifdef OBUF4_PIN_ARBITER_GUARD_EN
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);
    logic [3:0]           r_guard, w_guard_next;
`endif

    logic [NUM_REQ-1:0]   w_winner;
    logic                 w_valid;
    logic [PTR_W-1:0]     w_win_idx;
    logic [PTR_W-1:0]     w_idx_inc;
    logic [3:0]           w_data_arr [NUM_REQ];
    logic                 w_hold_hit;
    logic                 w_exit;

    obuf4_pin_arbiter_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req    (bus.req_i),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_data
            assign w_data_arr[gi] = bus.data_i[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    assign w_idx_inc  = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
    // The hold limit wins over a simultaneous request drop, so that case
    // still reports a timeout.
    assign w_hold_hit = (r_hold == HOLD_LAST);
    assign w_exit     = w_hold_hit || !bus.req_i[r_idx];

    always_comb begin
        w_state_next   = r_state;
        w_gnt_next     = r_gnt;
        w_idx_next     = r_idx;
        w_rr_ptr_next  = r_rr_ptr;
        w_pins_next    = IDLE_VAL;
        w_timeout_next = 1'b0;
        w_hold_next    = r_hold;
`ifdef OBUF4_PIN_ARBITER_GUARD_EN
        w_guard_next   = r_guard;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_state_next = ST_GRANT;
                    w_gnt_next   = w_winner;
                    w_idx_next   = w_win_idx;
                    w_hold_next  = '0;
                end
            end
            ST_GRANT: begin
                if (w_exit) begin
                    w_gnt_next     = '0;
                    w_rr_ptr_next  = w_idx_inc;
                    w_timeout_next = w_hold_hit;
`ifdef OBUF4_PIN_ARBITER_GUARD_EN
                    w_state_next   = ST_GUARD;
                    w_guard_next   = '0;
`else
                    w_state_next   = ST_IDLE;
`endif
                end else begin
                    w_pins_next = w_data_arr[r_idx];
                    w_hold_next = r_hold + 1'b1;
                end
            end
`ifdef OBUF4_PIN_ARBITER_GUARD_EN
            ST_GUARD: begin
                if (r_guard == GUARD_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_guard_next = r_guard + 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_idx     <= '0;
            r_rr_ptr  <= '0;
            r_pins    <= IDLE_VAL;
            r_timeout <= 1'b0;
            r_hold    <= '0;
`ifdef OBUF4_PIN_ARBITER_GUARD_EN
            r_guard   <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_gnt     <= w_gnt_next;
            r_idx     <= w_idx_next;
            r_rr_ptr  <= w_rr_ptr_next;
            r_pins    <= w_pins_next;
            r_timeout <= w_timeout_next;
            r_hold    <= w_hold_next;
`ifdef OBUF4_PIN_ARBITER_GUARD_EN
            r_guard   <= w_guard_next;
`endif
        end
    end

    assign bus.gnt_o     = r_gnt;
    assign bus.pins_o    = r_pins;
    assign bus.busy_o    = (r_state != ST_IDLE);
    assign bus.timeout_o = r_timeout;

endmodule

// File: tb/tb_obuf4_pin_arbiter.sv
// -----------------------------------------------------------------------------
// tb_obuf4_pin_arbiter
// Directed bench for obuf4_pin_arbiter (NUM_REQ=4, MAX_HOLD=4, IDLE_VAL=0).
// Follows OBUF4_PIN_ARBITER_GUARD_EN so the expected gaps match either build.
// -----------------------------------------------------------------------------
module tb_obuf4_pin_arbiter;

    localparam int         NREQ = 4;
    localparam int         MAXH = 4;
    localparam logic [3:0] IDLE = 4'b0000;
`ifdef OBUF4_PIN_ARBITER_GUARD_EN
    localparam int         GUARD_EXTRA = 2;
`else
    localparam int         GUARD_EXTRA = 0;
`endif
    localparam logic       BUSY_AFTER_EXIT = (GUARD_EXTRA > 0);
    // requester nibbles: r0=C r1=5 r2=A r3=D
    localparam logic [15:0] DATA0 = 16'hDA5C;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    obuf4_pin_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    obuf4_pin_arbiter #(
        .NUM_REQ  (NREQ),
        .MAX_HOLD (MAXH),
        .IDLE_VAL (IDLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic [3:0] gnt, input logic [3:0] pins,
                               input logic busy, input logic tmo);
        check({tag, ".gnt"},  32'(bus.gnt_o),     32'(gnt));
        check({tag, ".pins"}, 32'(bus.pins_o),    32'(pins));
        check({tag, ".busy"}, 32'(bus.busy_o),    32'(busy));
        check({tag, ".tmo"},  32'(bus.timeout_o), 32'(tmo));
        $display("t=%0t %s req=%b gnt=%b pins=%h busy=%b tmo=%b", $time, tag,
                 bus.req_i, bus.gnt_o, bus.pins_o, bus.busy_o, bus.timeout_o);
    endtask

    // Cycles spent in GUARD after a grant ends (none in the default build).
    task automatic guard_gap(input string tag);
        for (int i = 0; i < GUARD_EXTRA; i++) begin
            tick;
            check({tag, ".guard_gnt"},  32'(bus.gnt_o),     32'(4'b0000));
            check({tag, ".guard_pins"}, 32'(bus.pins_o),    32'(IDLE));
            check({tag, ".guard_tmo"},  32'(bus.timeout_o), 32'(1'b0));
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] d, input int k);
        return d[4*k +: 4];
    endfunction

    initial begin
        logic [3:0] oh;
        rst         = 1'b1;
        bus.req_i   = '0;
        bus.data_i  = DATA0;
        tick;
        tick;
        expect_outs("reset", 4'b0000, IDLE, 1'b0, 1'b0);
        rst = 1'b0;

        // No requests: pins idle, no grant.
        for (int i = 0; i < 10; i++) begin
            tick;
            expect_outs("idle", 4'b0000, IDLE, 1'b0, 1'b0);
        end

        // Single requester 2, released before the hold limit.
        bus.req_i = 4'b0100;
        tick;
        expect_outs("t2.grant", 4'b0100, IDLE, 1'b1, 1'b0);
        bus.data_i = 16'h3A71;                 // others change, r2 still A
        tick;
        expect_outs("t2.data_a", 4'b0100, 4'hA, 1'b1, 1'b0);
        bus.data_i = 16'hF6E9;                 // r2 now 6
        tick;
        expect_outs("t2.data_6", 4'b0100, 4'h6, 1'b1, 1'b0);
        bus.req_i = 4'b0000;
        tick;
        expect_outs("t2.release", 4'b0000, IDLE, BUSY_AFTER_EXIT, 1'b0);
        guard_gap("t2");

        // Pointer now 3: requester 3 beats requester 0.
        bus.data_i = DATA0;
        bus.req_i  = 4'b1001;
        tick;
        expect_outs("ptr3.grant", 4'b1000, IDLE, 1'b1, 1'b0);
        bus.req_i = 4'b0000;
        tick;
        expect_outs("ptr3.release", 4'b0000, IDLE, BUSY_AFTER_EXIT, 1'b0);
        guard_gap("ptr3");

        // All requesting: strict rotation 0,1,2,3,0 with timeouts.
        bus.req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << (i % 4);
            tick;
            expect_outs($sformatf("rot%0d.grant", i), oh, IDLE, 1'b1, 1'b0);
            tick;
            expect_outs($sformatf("rot%0d.data", i), oh, nib(DATA0, i % 4), 1'b1, 1'b0);
            tick;
            tick;
            expect_outs($sformatf("rot%0d.last", i), oh, nib(DATA0, i % 4), 1'b1, 1'b0);
            tick;
            expect_outs($sformatf("rot%0d.timeout", i), 4'b0000, IDLE, BUSY_AFTER_EXIT, 1'b1);
            guard_gap($sformatf("rot%0d", i));
        end
        bus.req_i = 4'b0000;
        tick;
        expect_outs("rot.after", 4'b0000, IDLE, 1'b0, 1'b0);

        // Requester 1 granted; requester 3 pulses during the grant and is lost.
        bus.req_i = 4'b0010;
        tick;
        expect_outs("t4.grant", 4'b0010, IDLE, 1'b1, 1'b0);
        bus.req_i = 4'b1010;
        tick;
        expect_outs("t4.pulse1", 4'b0010, nib(DATA0, 1), 1'b1, 1'b0);
        tick;
        expect_outs("t4.pulse2", 4'b0010, nib(DATA0, 1), 1'b1, 1'b0);
        bus.req_i = 4'b0010;
        tick;
        expect_outs("t4.last", 4'b0010, nib(DATA0, 1), 1'b1, 1'b0);
        bus.req_i = 4'b0000;                   // drop coincides with hold limit
        tick;
        expect_outs("t4.drop_timeout", 4'b0000, IDLE, BUSY_AFTER_EXIT, 1'b1);
        guard_gap("t4");
        tick;
        expect_outs("t4.no_r3", 4'b0000, IDLE, 1'b0, 1'b0);

        // Reset in the middle of a grant to requester 2.
        bus.req_i = 4'b0100;
        tick;
        expect_outs("t5.grant", 4'b0100, IDLE, 1'b1, 1'b0);
        tick;
        expect_outs("t5.data", 4'b0100, nib(DATA0, 2), 1'b1, 1'b0);
        rst = 1'b1;
        tick;
        expect_outs("t5.reset", 4'b0000, IDLE, 1'b0, 1'b0);
        rst       = 1'b0;
        bus.req_i = 4'b1010;                   // pointer back at 0 -> requester 1
        tick;
        expect_outs("t5.regrant", 4'b0010, IDLE, 1'b1, 1'b0);
        tick;
        expect_outs("t5.redata", 4'b0010, nib(DATA0, 1), 1'b1, 1'b0);
        bus.req_i = 4'b0000;
        tick;
        expect_outs("t5.release", 4'b0000, IDLE, BUSY_AFTER_EXIT, 1'b0);
        guard_gap("t5");
        tick;
        expect_outs("t5.idle", 4'b0000, IDLE, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
